// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit for the pipelined RV32I core. Turns the
//   M-stage load/store controls into a single byte-lane-masked word request
//   on a req/ack data port, extends returned load data, and stalls the
//   pipeline until the access completes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   MemReadM/MemWriteM  load / store in M stage
//   AddressingControlM  funct3 (b, h, w, bu, hu)
//   ALUResultM          byte address
//   WriteDataM          store data (rs2)
//   StallM              freeze F/D/E/M pipeline registers
//   ReadDataM           extended load result (registered, held until next load)
//   ReadValidM          one-cycle strobe: ReadDataM belongs to current load
//   AccessFaultM        misaligned / illegal access, no request issued
//   mem_*               word-addressed req/ack data-memory port
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic [2:0]              AddressingControlM,
    input  logic [DATA_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    output logic                    StallM,
    output logic [DATA_WIDTH-1:0]   ReadDataM,
    output logic                    ReadValidM,
    output logic                    AccessFaultM,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [3:0]              mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    // access attributes kept for load data extraction on ack
    logic [2:0] f3_q;
    logic [1:0] off_q;

    // ---------------- decode / legality ----------------
    logic        ld_legal, st_legal, aligned, access, ok, fault;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    always_comb begin
        ld_legal  = 1'b0;
        st_legal  = 1'b0;
        aligned   = 1'b0;
        be_nxt    = 4'b1111;
        wdata_nxt = '0;
        case (AddressingControlM)
            3'b000: begin ld_legal = 1'b1; st_legal = 1'b1; aligned = 1'b1; end
            3'b001: begin ld_legal = 1'b1; st_legal = 1'b1; aligned = ~ALUResultM[0]; end
            3'b010: begin ld_legal = 1'b1; st_legal = 1'b1; aligned = (ALUResultM[1:0] == 2'b00); end
            3'b100: begin ld_legal = 1'b1; aligned = 1'b1; end
            3'b101: begin ld_legal = 1'b1; aligned = ~ALUResultM[0]; end
            default: ;
        endcase

        access = MemReadM | MemWriteM;
        ok     = access && !(MemReadM && MemWriteM) && aligned &&
                 (MemReadM ? ld_legal : st_legal);
        fault  = access && !ok;

        // store lane steering; loads always fetch the whole word
        if (MemWriteM) begin
            case (AddressingControlM[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << ALUResultM[1:0];
                    wdata_nxt = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'b0011 << ALUResultM[1:0];
                    wdata_nxt = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = WriteDataM;
                end
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt    = state;
        StallM       = 1'b0;
        AccessFaultM = 1'b0;
        ReadValidM   = 1'b0;
        case (state)
            IDLE: begin
                StallM       = ok;
                AccessFaultM = fault;
                if (ok) state_nxt = BUSY;
            end
            BUSY: begin
                StallM = 1'b1;
                if (mem_ack) state_nxt = DONE;
            end
            DONE: begin
                // M-stage inputs still show the finished instruction here
                ReadValidM = ~mem_we;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- load extraction ----------------
    logic [31:0] shifted;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        ld_b    = shifted[7:0];
        ld_h    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_ext = {24'b0, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_ext = {16'b0, ld_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            ReadDataM <= '0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ok) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUResultM[31:2], 2'b00};
                mem_wdata <= wdata_nxt;
                mem_be    <= be_nxt;
                f3_q      <= AddressingControlM;
                off_q     <= ALUResultM[1:0];
            end else if (state == BUSY && mem_ack) begin
                mem_req <= 1'b0;
                if (!mem_we) ReadDataM <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  AddressingControlM = '0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic        StallM, ReadValidM, AccessFaultM;
    logic [31:0] ReadDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .AddressingControlM(AddressingControlM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .ReadValidM(ReadValidM),
        .AccessFaultM(AccessFaultM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rd[$];
    logic [31:0] mem[int unsigned];
    int checks = 0, errors = 0;
    int wait_n = 0;
    int wcnt = 0;
    logic req_prev = 1'b0;
    req_t held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // monitor + memory responder, both sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            req_prev = 1'b0;
            mem_ack  = 1'b0;
            wcnt     = 0;
        end else begin
            if (mem_req && !req_prev) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_req", {31'b0, mem_req}, 32'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("req_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("req_addr", mem_addr, e.addr);
                    chk("req_be", {28'b0, mem_be}, {28'b0, e.be});
                    if (e.we) chk("req_wdata", mem_wdata, e.wdata);
                end
                held = '{mem_we, mem_addr, mem_wdata, mem_be};
            end else if (mem_req) begin
                chk("req_stable", {mem_addr[31:2], mem_be, mem_we},
                    {held.addr[31:2], held.be, held.we});
            end
            if (ReadValidM) begin
                if (exp_rd.size() == 0) chk("unexpected_rvalid", {31'b0, ReadValidM}, 32'd0);
                else chk("read_data", ReadDataM, exp_rd.pop_front());
            end
            req_prev = mem_req;

            if (mem_req) begin
                if (wcnt >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    if (mem_we) begin
                        logic [31:0] w;
                        w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                        mem[mem_addr] = w;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                wcnt++;
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    task automatic idle_inputs();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    // present one M-stage access; expectations are pushed to the scoreboard
    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int w, input logic flt,
                          input logic [31:0] eaddr, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        int ns, nr, n;
        @(posedge clk); #1;
        wait_n = w;
        MemReadM = rd; MemWriteM = wr; AddressingControlM = f3;
        ALUResultM = a; WriteDataM = wd;
        if (!flt) begin
            exp_req.push_back('{wr, eaddr, ewd, ebe});
            if (rd) exp_rd.push_back(erd);
        end
        ns = 0; nr = 0; n = 0;
        @(negedge clk);
        if (flt) begin
            chk({nm, "_fault"}, {31'b0, AccessFaultM}, 32'd1);
            chk({nm, "_fault_stall"}, {31'b0, StallM}, 32'd0);
            chk({nm, "_fault_req"}, {31'b0, mem_req}, 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk({nm, "_fault_noreq"}, {31'b0, mem_req}, 32'd0);
        end else begin
            chk({nm, "_nofault"}, {31'b0, AccessFaultM}, 32'd0);
            while (StallM && n < 50) begin
                ns++;
                if (mem_req) nr++;
                @(negedge clk);
                n++;
            end
            chk({nm, "_stall_cycles"}, ns, 2 + w);
            chk({nm, "_req_cycles"}, nr, 1 + w);
            chk({nm, "_done_rvalid"}, {31'b0, ReadValidM}, {31'b0, rd});
            chk({nm, "_done_req"}, {31'b0, mem_req}, 32'd0);
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    initial begin
        int n;
        mem[32'h200] = 32'h80F0_7F81;

        // reset state
        #12;
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", {28'b0, mem_be}, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_rvalid", {31'b0, ReadValidM}, 0);
        chk("rst_fault", {31'b0, AccessFaultM}, 0);
        chk("rst_stall", {31'b0, StallM}, 0);
        #3 rst_n = 1'b1;

        // stores
        access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
        access("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 0);
        access("sh", 0, 1, 3'b001, 32'h102, 32'h00001234, 0, 0, 32'h100, 4'b1100, 32'h12341234, 0);
        access("lw_back", 1, 0, 3'b010, 32'h100, 0, 0, 0, 32'h100, 4'b1111, 0, 32'h1234BEEF);

        // loads from 0x80F07F81 @ 0x200
        access("lb", 1, 0, 3'b000, 32'h200, 0, 0, 0, 32'h200, 4'b1111, 0, 32'hFFFFFF81);
        access("lbu", 1, 0, 3'b100, 32'h200, 0, 0, 0, 32'h200, 4'b1111, 0, 32'h00000081);
        access("lh", 1, 0, 3'b001, 32'h202, 0, 0, 0, 32'h200, 4'b1111, 0, 32'hFFFF80F0);
        access("lhu", 1, 0, 3'b101, 32'h202, 0, 0, 0, 32'h200, 4'b1111, 0, 32'h000080F0);
        access("lw", 1, 0, 3'b010, 32'h200, 0, 0, 0, 32'h200, 4'b1111, 0, 32'h80F07F81);
        access("lb1", 1, 0, 3'b000, 32'h201, 0, 0, 0, 32'h200, 4'b1111, 0, 32'h0000007F);
        access("lb3", 1, 0, 3'b000, 32'h203, 0, 0, 0, 32'h200, 4'b1111, 0, 32'hFFFFFF80);

        // faults
        access("lw_mis", 1, 0, 3'b010, 32'h101, 0, 0, 1, 0, 0, 0, 0);
        access("lh_mis", 1, 0, 3'b001, 32'h203, 0, 0, 1, 0, 0, 0, 0);
        access("ld_f3_011", 1, 0, 3'b011, 32'h200, 0, 0, 1, 0, 0, 0, 0);
        access("st_f3_100", 0, 1, 3'b100, 32'h200, 0, 0, 1, 0, 0, 0, 0);
        access("rd_and_wr", 1, 1, 3'b010, 32'h200, 0, 0, 1, 0, 0, 0, 0);
        access("sw_mis", 0, 1, 3'b010, 32'h102, 0, 0, 1, 0, 0, 0, 0);

        // wait-stated load
        access("lw_wait3", 1, 0, 3'b010, 32'h200, 0, 3, 0, 32'h200, 4'b1111, 0, 32'h80F07F81);

        // reset in BUSY: request abandoned, no read result expected
        @(posedge clk); #1;
        wait_n = 20;
        MemReadM = 1; MemWriteM = 0; AddressingControlM = 3'b010; ALUResultM = 32'h200;
        exp_req.push_back('{1'b0, 32'h200, 32'h0, 4'b1111});
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 5) begin @(negedge clk); n++; end
        chk("busy_before_reset", {31'b0, mem_req}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_req", {31'b0, mem_req}, 0);
        chk("reset_rvalid", {31'b0, ReadValidM}, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        access("lw_after_rst", 1, 0, 3'b010, 32'h200, 0, 0, 0, 32'h200, 4'b1111, 0, 32'h80F07F81);
        repeat (4) @(posedge clk);
        #1;

        chk("exp_req_drained", exp_req.size(), 0);
        chk("exp_rd_drained", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
